// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. One serial bit per CLK cycle (CLK is the baud clock).
// Frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit(s).
// Parity: even type = XOR of data, odd type = XNOR of data.
// Optional build macro UART_TX_STOP2_EN: two stop bits. The next frame can only be
// accepted in the second stop cycle.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [CNT_W-1:0]        w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic                    w_par_bit;
  logic                    w_stop_last;
  logic                    w_accept;
  logic                    w_tx_nxt;
  logic                    w_busy_nxt;

`ifdef UART_TX_STOP2_EN
  logic r_stop_cnt;

  // Stop-bit counter: 0 in the first stop cycle, 1 in the second.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stop_cnt <= 1'b0;
    end else if (r_state == ST_STOP) begin
      r_stop_cnt <= ~r_stop_cnt;
    end else begin
      r_stop_cnt <= 1'b0;
    end
  end

  assign w_stop_last = (r_state == ST_STOP) && r_stop_cnt;
`else
  assign w_stop_last = (r_state == ST_STOP);
`endif

  // A request is taken only when idle or in the final stop cycle.
  assign w_accept = DATA_VALID && ((r_state == ST_IDLE) || w_stop_last);

  // Parity is computed from the latched copy of the byte, never from live inputs.
  assign w_par_bit = r_par_typ ? ~(^r_data) : (^r_data);

  // Capture the payload and the framing options when a request is accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data    <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

  // State, bit counter and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      TX_OUT    <= w_tx_nxt;
      BUSY      <= w_busy_nxt;
    end
  end

  // Next state, next bit index and the line level that goes with the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = 1'b1;
    w_busy_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_stop_last) begin
          w_state_nxt = w_accept ? ST_START : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Counter clears on entry to DATA and saturates at the last data bit.
    if ((w_state_nxt == ST_DATA) && (r_state != ST_DATA)) begin
      w_bit_cnt_nxt = '0;
    end else if ((r_state == ST_DATA) && (r_bit_cnt != LAST_BIT)) begin
      w_bit_cnt_nxt = CNT_W'(r_bit_cnt + CNT_W'(1));
    end

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = r_data[w_bit_cnt_nxt];
      ST_PARITY: w_tx_nxt = w_par_bit;
      default:   w_tx_nxt = 1'b1;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx. Expected line levels come
// from a bit-queue frame model; outputs are sampled 1 ns after each rising edge.
// Define UART_TX_STOP2_EN for both bench and RTL to exercise the two-stop-bit build.
module tb_uart_tx;

  localparam int unsigned DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int unsigned NSTOP = 2;
`else
  localparam int unsigned NSTOP = 1;
`endif

  typedef logic bq_t[$];

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          BUSY;

  int n_chk;
  int n_pass;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference frame: list of line levels from the start bit through the last stop bit.
  function automatic bq_t frame_bits(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    bq_t q;
    int  ones;
    q.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) q.push_back(d[i]);
    if (pen) begin
      ones = $countones(d);
      // Even type makes total ones even; odd type makes total ones odd.
      q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    end
    for (int s = 0; s < int'(NSTOP); s++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one request at the falling edge; returns 1 ns after the accepting edge.
  task automatic accept(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #2 RST = 1'b0;
    #4;
    n_chk++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL reset_values tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0)
        $display("FAIL reset_idle[%0d] tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, BUSY);
      else n_pass++;
    end
  endtask

  // Directed frames from the test plan followed by random frames with random gaps.
  task automatic test_frames();
    logic [DW-1:0] d;
    logic          pen, ptyp;
    bq_t           q;
    logic          etx, ebusy;
    for (int f = 0; f < 30; f++) begin
      case (f)
        0: begin d = 8'hA5; pen = 1'b0; ptyp = 1'b0; end
        1: begin d = 8'hA5; pen = 1'b1; ptyp = 1'b0; end
        2: begin d = 8'hA5; pen = 1'b1; ptyp = 1'b1; end
        3: begin d = 8'h07; pen = 1'b1; ptyp = 1'b0; end
        4: begin d = 8'h07; pen = 1'b1; ptyp = 1'b1; end
        default: begin
          d = DW'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      accept(d, pen, ptyp);
      P_DATA = DW'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      q = frame_bits(d, pen, ptyp);
      for (int i = 0; i < q.size() + 2; i++) begin
        if (i > 0) step();
        etx   = (i < q.size()) ? q[i] : 1'b1;
        ebusy = (i < q.size());
        n_chk++;
        if (TX_OUT !== etx || BUSY !== ebusy)
          $display("FAIL frame%0d_d%02h_p%0d%0d[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                   f, d, pen, ptyp, i, TX_OUT, BUSY, etx, ebusy);
        else n_pass++;
      end
    end
  endtask

  // DATA_VALID held high; the second byte is presented only in the final stop cycle.
  task automatic test_back_to_back(input logic pen, input logic ptyp);
    bq_t q;
    bq_t q2;
    int  fl;
    logic etx, ebusy;
    q  = frame_bits(8'h3C, pen, ptyp);
    q2 = frame_bits(8'hC3, pen, ptyp);
    fl = q.size();
    foreach (q2[j]) q.push_back(q2[j]);
    accept(8'h3C, pen, ptyp);
    DATA_VALID = 1'b1;
    for (int i = 0; i < 2 * fl + 3; i++) begin
      if (i > 0) step();
      etx   = (i < 2 * fl) ? q[i] : 1'b1;
      ebusy = (i < 2 * fl);
      n_chk++;
      if (TX_OUT !== etx || BUSY !== ebusy)
        $display("FAIL back_to_back_p%0d%0d[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                 pen, ptyp, i, TX_OUT, BUSY, etx, ebusy);
      else n_pass++;
      P_DATA     = (i == fl - 1) ? 8'hC3 : 8'h3C;
      DATA_VALID = (i < 2 * fl - 1);
    end
    DATA_VALID = 1'b0;
  endtask

  // Requests during DATA and PARITY cycles of a frame must be dropped.
  task automatic test_ignore();
    bq_t  q;
    logic etx, ebusy;
    q = frame_bits(8'h00, 1'b1, 1'b0);
    accept(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < q.size() + 4; i++) begin
      if (i > 0) step();
      etx   = (i < q.size()) ? q[i] : 1'b1;
      ebusy = (i < q.size());
      n_chk++;
      if (TX_OUT !== etx || BUSY !== ebusy)
        $display("FAIL ignore_busy[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                 i, TX_OUT, BUSY, etx, ebusy);
      else n_pass++;
      P_DATA = 8'hFF;
      if (i >= 1 && i <= int'(DW))
        DATA_VALID = 1'($urandom);
      else
        DATA_VALID = (i == int'(DW) + 1);
    end
    DATA_VALID = 1'b0;
  endtask

  // Inputs toggled every cycle after acceptance must not disturb the frame.
  task automatic test_toggle();
    bq_t  q;
    logic etx, ebusy;
    q = frame_bits(8'h5A, 1'b1, 1'b0);
    accept(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < q.size() + 2; i++) begin
      if (i > 0) step();
      etx   = (i < q.size()) ? q[i] : 1'b1;
      ebusy = (i < q.size());
      n_chk++;
      if (TX_OUT !== etx || BUSY !== ebusy)
        $display("FAIL toggle[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                 i, TX_OUT, BUSY, etx, ebusy);
      else n_pass++;
      P_DATA  = ~P_DATA;
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
  endtask

  // Reset during data bit 4 clears the line at once; a fresh frame follows release.
  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    bq_t  q;
    logic etx, ebusy;
    d = DW'($urandom);
    accept(d, 1'b1, 1'($urandom));
    repeat (5) step();
    n_chk++;
    if (TX_OUT !== d[4] || BUSY !== 1'b1)
      $display("FAIL pre_reset_bit4 tx=%b busy=%b expected tx=%b busy=1", TX_OUT, BUSY, d[4]);
    else n_pass++;
    #1 RST = 1'b0;
    #1;
    n_chk++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL async_reset tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0)
        $display("FAIL post_reset_idle[%0d] tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, BUSY);
      else n_pass++;
    end
    q = frame_bits(8'h81, 1'b0, 1'b0);
    accept(8'h81, 1'b0, 1'b0);
    for (int i = 0; i < q.size() + 2; i++) begin
      if (i > 0) step();
      etx   = (i < q.size()) ? q[i] : 1'b1;
      ebusy = (i < q.size());
      n_chk++;
      if (TX_OUT !== etx || BUSY !== ebusy)
        $display("FAIL after_reset_81[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                 i, TX_OUT, BUSY, etx, ebusy);
      else n_pass++;
    end
  endtask

`ifdef UART_TX_STOP2_EN
  // A request during the first of two stop cycles must be dropped.
  task automatic test_stop2();
    bq_t  q;
    logic etx, ebusy;
    q = frame_bits(8'hA5, 1'b0, 1'b0);
    accept(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < q.size() + 4; i++) begin
      if (i > 0) step();
      etx   = (i < q.size()) ? q[i] : 1'b1;
      ebusy = (i < q.size());
      n_chk++;
      if (TX_OUT !== etx || BUSY !== ebusy)
        $display("FAIL stop2_first_window[%0d] tx=%b busy=%b expected tx=%b busy=%b",
                 i, TX_OUT, BUSY, etx, ebusy);
      else n_pass++;
      P_DATA     = 8'hFF;
      DATA_VALID = (i == q.size() - 2);
    end
    DATA_VALID = 1'b0;
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_frames();
    test_back_to_back(1'b0, 1'b0);
    test_back_to_back(1'b1, 1'($urandom));
    test_ignore();
    test_toggle();
    test_reset_midframe();
`ifdef UART_TX_STOP2_EN
    test_stop2();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit-side counterpart of the UART receiver and its parity checker. It accepts a parallel byte with a one-cycle valid strobe and serializes it onto TX_OUT as start bit, data LSB-first, optional parity bit, and stop bit. CLK is the baud clock: one serial bit per CLK cycle. The parity convention is identical to the receiver's checker: even-type parity bit = XOR of data; odd-type = XNOR of data.

## Interface
- DATA_WIDTH, 8, payload bits per frame.
- CLK  in  1  baud-rate clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- P_DATA  in  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
- DATA_VALID  in  1  request strobe; accepted only in an acceptance window (see Operation).
- PAR_EN  in  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  out  1  serial line, registered, idles high.
- BUSY  out  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance window: state IDLE, or the final stop-bit cycle of STOP. DATA_VALID is ignored in every other cycle; the frame in flight is never disturbed.
- On acceptance, the block latches P_DATA, PAR_EN, and PAR_TYP into internal registers. It computes parity from the latched data: parity_bit = PAR_TYP ? ~^data : ^data. Input changes after acceptance have no effect on the frame.
- START: TX_OUT=0 for 1 cycle, then DATA.
- DATA: TX_OUT = data[i], with i counting 0..DATA_WIDTH-1, one bit per cycle. After bit DATA_WIDTH-1, the next state is PARITY if the latched PAR_EN=1, else STOP.
- PARITY: TX_OUT=parity_bit for 1 cycle, then STOP.
- STOP: TX_OUT=1.
  - With DATA_VALID=1 in the last stop cycle, the next state is START with newly latched data (back-to-back, no idle gap).
  - Otherwise the next state is IDLE.
- IDLE: TX_OUT=1, BUSY=0.
- The bit counter width is $clog2(DATA_WIDTH). It clears on entering DATA and does not wrap past DATA_WIDTH-1.

## Timing
- Reset values: TX_OUT=1, BUSY=0, state IDLE, bit counter 0, data/parity registers 0.
- Asserting RST mid-frame forces these values immediately, without waiting for a clock. The partial frame is abandoned, and the line stays high until a new acceptance after RST deasserts.
- Acceptance at edge k:
  - TX_OUT=0 and BUSY=1 from edge k.
  - data[i] is on the line from edge k+1+i.
  - Parity bit (if PAR_EN) from edge k+1+DATA_WIDTH.
  - Stop bit follows.
- Frame length, start edge to end of stop: 10 cycles without parity, 11 with parity (DATA_WIDTH=8).
- BUSY falls at the edge where STOP exits to IDLE. BUSY stays 1 across back-to-back frames.
- Latency from DATA_VALID to start bit: 1 edge.
- Frame period for continuous streaming equals the frame length.
- DATA_VALID held high continuously: a new frame is accepted in every acceptance window; no frame is duplicated or skipped.

## Configuration
- Macro: UART_TX_STOP2_EN.
- Defined: STOP lasts 2 cycles (two stop bits). The acceptance window is the second stop cycle only, and frame length grows by 1 (11/12 cycles).
- Undefined: exactly one stop bit, as described above.

## Test plan
- Reset, then 0xA5 with PAR_EN=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY is high for exactly 10 cycles, then TX_OUT stays 1.
- 0xA5 with PAR_EN=1:
  - PAR_TYP=0 -> parity bit 0, frame of 11 bits.
  - PAR_TYP=1 -> parity bit 1.
  - Repeat with 0x07: even gives 1, odd gives 0.
- DATA_VALID held high with P_DATA=0x3C, then 0xC3 presented in the stop cycle -> two contiguous frames with no idle bit between them. BUSY stays 1; the second frame carries 0xC3.
- DATA_VALID pulses with 0xFF during DATA and PARITY cycles of a 0x00 frame -> pulses ignored. The 0x00 frame completes intact and no second frame follows.
- P_DATA, PAR_EN, and PAR_TYP toggled every cycle after acceptance of 0x5A with even parity -> the line carries 0x5A with parity 0, unaffected by the toggling.
- RST asserted mid-data-bit 4 -> TX_OUT=1 and BUSY=0 immediately. After release, a new 0x81 frame transmits correctly.
- With UART_TX_STOP2_EN defined -> two consecutive 1 bits after each frame, and back-to-back acceptance only in the second stop cycle.
